verificador_paridade: RTL and testbench
=======================================

# verificador_paridade

Receiving-side parity checker sitting directly downstream of the error injector: it accepts 9-bit words (8 data bits plus 1 parity bit) over a valid/ready handshake, checks even parity, and forwards the data byte with an error flag through a one-entry output register. It keeps saturating word and error counters, and raises an alarm after a run of consecutive parity errors.

## Interface
- LIMIAR_ALARME, default 3: consecutive erroneous words needed to raise `alarme`; legal range 1..255.
- LARGURA_CONT, default 8: width of `cont_palavras` and `cont_erros`.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- entrada  input  9  word: [7:0] data, [8] parity bit.
- entrada_valida  input  1  `entrada` holds a word.
- entrada_pronta  output  1  the block can accept a word this cycle.
- saida_dados  output  8  registered data byte.
- saida_erro  output  1  registered parity-error flag for `saida_dados`.
- saida_valida  output  1  the output register holds a word.
- saida_pronta  input  1  the consumer takes the output word this cycle.
- cont_palavras  output  LARGURA_CONT  saturating count of accepted words.
- cont_erros  output  LARGURA_CONT  saturating count of accepted words with a parity error.
- alarme  output  1  error-burst alarm.
- limpar_alarme  input  1  synchronous alarm clear.

## Operation
- **Parity rule.** Even parity over all 9 bits. `erro_calc` is the XOR of `entrada[8:0]`. 1 means error.
- **Accept.** A word is accepted when `entrada_valida && entrada_pronta`.
- **Ready.** `entrada_pronta = !saida_valida || saida_pronta`. This is combinational, so no bubble occurs when output is drained every cycle.
- **On accept:**
  - `saida_dados <= entrada[7:0]`
  - `saida_erro <= erro_calc`
  - `saida_valida <= 1`
- **Drain.** On `saida_valida && saida_pronta` with no accept in the same cycle: `saida_valida <= 0`. `saida_dados` and `saida_erro` hold their last value.
- **Stall.** While `saida_valida && !saida_pronta`, the output register is stable. `entrada_pronta` is 0.
- **Counters.**
  - On accept, `cont_palavras` increments.
  - If `erro_calc` is also 1, `cont_erros` increments.
  - Both saturate at all-ones. Neither wraps.
- **Consecutive-error counter `seq`.** Internal, saturates at LIMIAR_ALARME.
  - Accepted erroneous word: `seq + 1`.
  - Accepted good word: 0.
  - No accept: hold.
- **Alarm FSM.**
  - States:
    - NORMAL: `seq == 0`.
    - SUSPEITA: `0 < seq < LIMIAR_ALARME`.
    - ALARME: alarm raised.
  - NORMAL/SUSPEITA → ALARME on the accept that makes `seq` reach LIMIAR_ALARME. With LIMIAR_ALARME = 1, NORMAL goes straight to ALARME.
  - SUSPEITA → NORMAL on an accepted good word.
  - ALARME is sticky. Good words do not leave it, though they still reset `seq`.
  - ALARME exits only on `limpar_alarme`, which goes to NORMAL with `seq <= 0`.
  - `alarme` = (state == ALARME), registered.
- **Simultaneous clear and erroneous accept.** Clear wins: state NORMAL, `seq` = 0. The word is still counted in `cont_palavras`/`cont_erros` and flagged in `saida_erro`.
- **Clear elsewhere.** `limpar_alarme` outside ALARME also forces NORMAL and `seq` = 0.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `saida_*` after edge N. Counters and `alarme` update at the same edge.
- Throughput is 1 word per cycle when `saida_pronta` is held at 1.
- Reset values, applied asynchronously on `rst_n` = 0:
  - `saida_dados` = 0, `saida_erro` = 0, `saida_valida` = 0.
  - `cont_palavras` = 0, `cont_erros` = 0.
  - `alarme` = 0, `seq` = 0, state NORMAL.
  - `entrada_pronta` = 1 while in reset, following from `saida_valida` = 0.
- Reset mid-transfer drops the held word. No partial update survives.
- Upstream must hold `entrada` and `entrada_valida` stable until accepted.

## Configuration
- **`VERIFICADOR_ALARME_EN` defined:** `seq`, the alarm FSM, `alarme` and `limpar_alarme` behave as described above.
- **Not defined:**
  - The FSM and `seq` are not built.
  - `alarme` is tied to 0 and `limpar_alarme` is ignored.
  - Handshake, data path and counters are unchanged.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-stream → all outputs at reset values immediately, without waiting for a clock edge, and `entrada_pronta` = 1.
- **Good and bad words.** Stream 0x0AA, 0x1AA, 0x107 with `saida_pronta` = 1 → `saida_dados` AA/AA/07 with `saida_erro` 0/1/0 on consecutive cycles, `cont_palavras` = 3, `cont_erros` = 1.
- **Backpressure.** Hold `saida_pronta` = 0 for 4 cycles with `entrada_valida` = 1 → `entrada_pronta` = 0, output frozen, counters unchanged. Release → the next word is accepted the same cycle.
- **Alarm, LIMIAR = 3.** Inputs 0x1AA, 0x1AA, 0x0AA, 0x1AA ×3 → `alarme` rises after the 6th accept only. Then 0x0AA → `alarme` stays 1. Then `limpar_alarme` coincident with 0x1AA → `alarme` = 0 and `cont_erros` increments.
- **Saturation.** LARGURA_CONT = 4, 20 erroneous words → `cont_palavras` = `cont_erros` = 15, no wrap.
- **Macro off.** Build without `VERIFICADOR_ALARME_EN` and repeat the alarm scenario → `alarme` stays 0 and counters match the macro-on run.

Source files
------------

// File: rtl/verificador_paridade.sv
// Even-parity checker for 9-bit words with a one-entry output register,
// saturating counters and an error-burst alarm built when VERIFICADOR_ALARME_EN is defined.
`timescale 1ns/1ps
module verificador_paridade #(
  parameter int LIMIAR_ALARME = 3,
  parameter int LARGURA_CONT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8:0]              entrada,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  output logic [7:0]              saida_dados,
  output logic                    saida_erro,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  output logic [LARGURA_CONT-1:0] cont_palavras,
  output logic [LARGURA_CONT-1:0] cont_erros,
  output logic                    alarme,
  input  logic                    limpar_alarme
);

  localparam logic [LARGURA_CONT-1:0] CONT_UM    = LARGURA_CONT'(1);
  localparam logic [LARGURA_CONT-1:0] CONT_CHEIO = '1;

  function automatic logic [LARGURA_CONT-1:0] incr_sat(input logic [LARGURA_CONT-1:0] v);
    incr_sat = (v == CONT_CHEIO) ? v : v + CONT_UM;
  endfunction

  logic       erro_p0;
  logic       aceita_p0;
  logic       vld_p1;
  logic [7:0] dados_p1;
  logic       erro_p1;
  logic [LARGURA_CONT-1:0] palavras_p1;
  logic [LARGURA_CONT-1:0] erros_p1;

  assign erro_p0        = ^entrada;
  assign entrada_pronta = !vld_p1 || saida_pronta;
  assign aceita_p0      = entrada_valida && entrada_pronta;

  // p0 -> p1: output register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      dados_p1 <= '0;
      erro_p1  <= 1'b0;
    end else if (aceita_p0) begin
      vld_p1   <= 1'b1;
      dados_p1 <= entrada[7:0];
      erro_p1  <= erro_p0;
    end else if (saida_pronta) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      palavras_p1 <= '0;
      erros_p1    <= '0;
    end else if (aceita_p0) begin
      palavras_p1 <= incr_sat(palavras_p1);
      if (erro_p0)
        erros_p1  <= incr_sat(erros_p1);
    end
  end

  assign saida_valida  = vld_p1;
  assign saida_dados   = dados_p1;
  assign saida_erro    = erro_p1;
  assign cont_palavras = palavras_p1;
  assign cont_erros    = erros_p1;

`ifdef VERIFICADOR_ALARME_EN
  typedef enum logic [1:0] {NORMAL, SUSPEITA, ALARME} estado_t;

  localparam logic [7:0] LIMIAR = 8'(LIMIAR_ALARME);

  function automatic logic [7:0] seq_sat(input logic [7:0] v);
    seq_sat = (v >= LIMIAR) ? LIMIAR : v + 8'd1;
  endfunction

  estado_t    estado_p1, estado_prox;
  logic [7:0] seq_p1, seq_prox;
  logic       alarme_p1;

  always_comb begin
    estado_prox = estado_p1;
    seq_prox    = seq_p1;
    if (limpar_alarme) begin
      estado_prox = NORMAL;
      seq_prox    = 8'd0;
    end else if (aceita_p0) begin
      seq_prox = erro_p0 ? seq_sat(seq_p1) : 8'd0;
      // ALARME is sticky; only the clear above leaves it
      if (estado_p1 != ALARME) begin
        if (seq_prox == LIMIAR)
          estado_prox = ALARME;
        else if (seq_prox == 8'd0)
          estado_prox = NORMAL;
        else
          estado_prox = SUSPEITA;
      end
    end
  end

  // p0 -> p1: alarm state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_p1 <= NORMAL;
      seq_p1    <= 8'd0;
      alarme_p1 <= 1'b0;
    end else begin
      estado_p1 <= estado_prox;
      seq_p1    <= seq_prox;
      alarme_p1 <= (estado_prox == ALARME);
    end
  end

  assign alarme = alarme_p1;
`else
  logic unused_limpar;
  assign unused_limpar = limpar_alarme;
  assign alarme        = 1'b0;
`endif

endmodule

// File: tb/tb_verificador_paridade.sv
// Bench for verificador_paridade: two instances (LIMIAR 3 / 8-bit counters and
// LIMIAR 1 / 4-bit counters) fed the same stream and checked against a behavioural model.
`timescale 1ns/1ps
module tb_verificador_paridade;

`ifdef VERIFICADOR_ALARME_EN
  localparam bit ALARME_EN = 1'b1;
`else
  localparam bit ALARME_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] entrada;
  logic       entrada_valida;
  logic       saida_pronta;
  logic       limpar_alarme;

  logic       a_pronta, b_pronta;
  logic [7:0] a_dados, b_dados;
  logic       a_erro, b_erro, a_valida, b_valida, a_alarme, b_alarme;
  logic [7:0] a_cw, a_ce;
  logic [3:0] b_cw, b_ce;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  verificador_paridade #(.LIMIAR_ALARME(3), .LARGURA_CONT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
    .entrada_pronta(a_pronta), .saida_dados(a_dados), .saida_erro(a_erro),
    .saida_valida(a_valida), .saida_pronta(saida_pronta), .cont_palavras(a_cw),
    .cont_erros(a_ce), .alarme(a_alarme), .limpar_alarme(limpar_alarme));

  verificador_paridade #(.LIMIAR_ALARME(1), .LARGURA_CONT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
    .entrada_pronta(b_pronta), .saida_dados(b_dados), .saida_erro(b_erro),
    .saida_valida(b_valida), .saida_pronta(saida_pronta), .cont_palavras(b_cw),
    .cont_erros(b_ce), .alarme(b_alarme), .limpar_alarme(limpar_alarme));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a held word, plain integer counts and a run length of errors.
  int   lim  [2] = '{3, 1};
  int   maxc [2] = '{255, 15};
  logic m_vld;
  logic [7:0] m_dat;
  logic m_err;
  int   m_cw [2];
  int   m_ce [2];
  int   m_run[2];
  bit   m_al [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      m_dat <= 8'h00;
      m_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_cw[i] <= 0; m_ce[i] <= 0; m_run[i] <= 0; m_al[i] <= 1'b0;
      end
    end else begin
      automatic bit acc = entrada_valida && (!m_vld || saida_pronta);
      automatic bit par = ($countones(entrada) % 2) == 1;
      if (acc) begin
        m_vld <= 1'b1; m_dat <= entrada[7:0]; m_err <= par;
      end else if (saida_pronta) begin
        m_vld <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        automatic int run = m_run[i];
        if (acc) m_cw[i] <= (m_cw[i] + 1 > maxc[i]) ? maxc[i] : m_cw[i] + 1;
        if (acc && par) m_ce[i] <= (m_ce[i] + 1 > maxc[i]) ? maxc[i] : m_ce[i] + 1;
        if (limpar_alarme) begin
          m_run[i] <= 0; m_al[i] <= 1'b0;
        end else if (acc) begin
          run = par ? ((run < 1000) ? run + 1 : run) : 0;
          m_run[i] <= run;
          if (run >= lim[i]) m_al[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_pronta", a_pronta, !m_vld || saida_pronta);
      chk("b_pronta", b_pronta, !m_vld || saida_pronta);
      chk("a_valida", a_valida, m_vld);
      chk("b_valida", b_valida, m_vld);
      chk("a_dados", a_dados, m_dat);
      chk("b_dados", b_dados, m_dat);
      chk("a_erro", a_erro, m_err);
      chk("b_erro", b_erro, m_err);
      chk("a_cont_palavras", a_cw, m_cw[0]);
      chk("a_cont_erros", a_ce, m_ce[0]);
      chk("b_cont_palavras", b_cw, m_cw[1]);
      chk("b_cont_erros", b_ce, m_ce[1]);
      chk("a_alarme", a_alarme, ALARME_EN ? m_al[0] : 1'b0);
      chk("b_alarme", b_alarme, ALARME_EN ? m_al[1] : 1'b0);
    end
  end

  // Drive inputs, then move to 3 time units after the next rising edge.
  task automatic put(input logic [8:0] w, input logic v, input logic p, input logic c);
    entrada = w; entrada_valida = v; saida_pronta = p; limpar_alarme = c;
    @(posedge clk); #3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    entrada_valida = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_d [3];
    logic       exp_e [3];
    logic [8:0] words [3];
    logic [8:0] burst [6];
    bit         acc_prev;
    words = '{9'h0AA, 9'h1AA, 9'h107};
    exp_d = '{8'hAA, 8'hAA, 8'h07};
    exp_e = '{1'b0, 1'b1, 1'b0};
    burst = '{9'h1AA, 9'h1AA, 9'h0AA, 9'h1AA, 9'h1AA, 9'h1AA};

    rst_n = 1'b0; entrada = 9'h0; entrada_valida = 1'b0;
    saida_pronta = 1'b1; limpar_alarme = 1'b0;
    #1;
    chk("reset_valida", a_valida, 0);
    chk("reset_pronta", a_pronta, 1);
    chk("reset_cont", a_cw, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Good and bad words
    for (int i = 0; i < 3; i++) begin
      put(words[i], 1'b1, 1'b1, 1'b0);
      chk("seq_dados", a_dados, exp_d[i]);
      chk("seq_erro", a_erro, exp_e[i]);
    end
    chk("seq_cont_palavras", a_cw, 3);
    chk("seq_cont_erros", a_ce, 1);

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      entrada = 9'h055; entrada_valida = 1'b1; saida_pronta = 1'b0;
      #1;
      chk("stall_pronta", a_pronta, 0);
      @(posedge clk); #3;
      chk("stall_dados", a_dados, 8'h07);
      chk("stall_cont", a_cw, 3);
    end
    saida_pronta = 1'b1;
    #1;
    chk("release_pronta", a_pronta, 1);
    @(posedge clk); #3;
    chk("release_dados", a_dados, 8'h55);
    chk("release_cont", a_cw, 4);

    // Asynchronous reset mid-stream
    entrada = 9'h1FF; entrada_valida = 1'b1; saida_pronta = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valida", a_valida, 0);
    chk("arst_dados", a_dados, 0);
    chk("arst_cont", a_cw, 0);
    chk("arst_pronta", a_pronta, 1);
    @(posedge clk); #3;
    rst_n = 1'b1; entrada_valida = 1'b0; saida_pronta = 1'b1;

    // Alarm burst
    for (int i = 0; i < 6; i++) begin
      put(burst[i], 1'b1, 1'b1, 1'b0);
      chk("burst_alarme_a", a_alarme, (ALARME_EN && i == 5) ? 1 : 0);
      chk("burst_alarme_b", b_alarme, ALARME_EN ? 1 : 0);
    end
    put(9'h0AA, 1'b1, 1'b1, 1'b0);
    chk("sticky_alarme_a", a_alarme, ALARME_EN ? 1 : 0);
    put(9'h1AA, 1'b1, 1'b1, 1'b1);
    chk("clear_alarme_a", a_alarme, 0);
    chk("clear_alarme_b", b_alarme, 0);
    chk("clear_cont_erros", a_ce, 6);
    chk("clear_cont_palavras", a_cw, 8);
    chk("clear_erro_flag", a_erro, 1);
    limpar_alarme = 1'b0;

    // Saturation of the narrow counters
    do_reset();
    for (int i = 0; i < 20; i++) put(9'h1AA, 1'b1, 1'b1, 1'b0);
    chk("sat_b_palavras", b_cw, 15);
    chk("sat_b_erros", b_ce, 15);
    chk("sat_a_palavras", a_cw, 20);
    chk("sat_a_erros", a_ce, 20);

    // Randomized traffic, upstream holds a word until it is accepted
    do_reset();
    acc_prev = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      saida_pronta  = ($urandom_range(0, 3) != 0);
      limpar_alarme = ($urandom_range(0, 15) == 0);
      if (!entrada_valida || acc_prev) begin
        entrada_valida = ($urandom_range(0, 4) != 0);
        entrada        = ($urandom_range(0, 1) != 0) ? 9'({$urandom_range(0, 1)}) << 8 | 9'h0AA
                                                     : 9'($urandom_range(0, 511));
      end
      #1;
      acc_prev = entrada_valida && a_pronta;
      @(posedge clk); #3;
      if (n == 1500) do_reset();
    end
    entrada_valida = 1'b0; limpar_alarme = 1'b0;
    @(posedge clk); #3;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
